// File: rtl/dm_access_if.sv
//------------------------------------------------------------------------------
// dm_access_if : EX/MEM request, data-memory port, MEM/WB result and error record
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dm_access_if #(
    parameter int AW = 11
);
    logic          req_valid;
    logic          req_rd;
    logic          req_wr;
    logic [1:0]    req_size;
    logic          req_uns;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [4:0]    req_dst;
    logic          stall;
    logic          flush;
    logic          err_clr;

    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wd;
    logic [3:0]    dm_be;
    logic [31:0]   dm_rd;

    logic          wb_valid;
    logic          wb_we;
    logic [4:0]    wb_dst;
    logic [31:0]   wb_data;
    logic          err_valid;
    logic [31:0]   err_addr;
    logic          err_store;

    modport slave (
        input  req_valid, req_rd, req_wr, req_size, req_uns, req_addr, req_wdata, req_dst,
        input  stall, flush, err_clr, dm_rd,
        output dm_addr, dm_wd, dm_be,
        output wb_valid, wb_we, wb_dst, wb_data, err_valid, err_addr, err_store
    );

    modport master (
        output req_valid, req_rd, req_wr, req_size, req_uns, req_addr, req_wdata, req_dst,
        output stall, flush, err_clr, dm_rd,
        input  dm_addr, dm_wd, dm_be,
        input  wb_valid, wb_we, wb_dst, wb_data, err_valid, err_addr, err_store
    );
endinterface

`default_nettype wire

// File: rtl/dm_access_unit.sv
//------------------------------------------------------------------------------
// dm_access_unit : MEM-stage load/store unit with lane steering, load extension
//                  and a sticky misalignment record
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dm_access_unit #(
    parameter int ADDR_LSB = 2,
    parameter int ADDR_MSB = 12
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    dm_access_if.slave  bus
);
    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b10;

    logic        w_legal, w_active, w_misal, w_go, w_st, w_ld;
    logic [3:0]  w_be;
    logic [31:0] w_wd, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [4:0]  wb_dst_q, wb_dst_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_valid_q, err_valid_d, err_store_q, err_store_d;
    logic [31:0] err_addr_q, err_addr_d;

    wire w_unused_addr = &{1'b0, bus.req_addr[31:ADDR_MSB+1]};

    assign w_legal  = (bus.req_rd ^ bus.req_wr) && (bus.req_size != 2'b11);
    assign w_active = bus.req_valid && !bus.flush && !bus.stall && w_legal;
    assign w_misal  = ((bus.req_size == C_SZ_HALF) && bus.req_addr[0]) ||
                      ((bus.req_size == C_SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    assign w_go     = w_active && !w_misal;
    assign w_st     = w_go && bus.req_wr;
    assign w_ld     = w_go && bus.req_rd;

    assign bus.dm_addr = bus.req_addr[ADDR_MSB:ADDR_LSB];

    always_comb begin
        w_be = 4'b0000;
        w_wd = bus.req_wdata;
        if (w_st) begin
            case (bus.req_size)
                C_SZ_BYTE: begin
                    w_be = 4'b0001 << bus.req_addr[1:0];
                    w_wd = {4{bus.req_wdata[7:0]}};
                end
                C_SZ_HALF: begin
                    w_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wd = {2{bus.req_wdata[15:0]}};
                end
                default: w_be = 4'b1111;
            endcase
        end
    end

    // Byte enables are gated by reset so no store can reach memory while held in reset.
    assign bus.dm_be = rst_n ? w_be : 4'b0000;
    assign bus.dm_wd = w_wd;

    assign w_byte = bus.dm_rd[{bus.req_addr[1:0], 3'b000} +: 8];
    assign w_half = bus.dm_rd[{bus.req_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (bus.req_size)
            C_SZ_BYTE: w_ext = {{24{w_byte[7] & ~bus.req_uns}}, w_byte};
            C_SZ_HALF: w_ext = {{16{w_half[15] & ~bus.req_uns}}, w_half};
            default:   w_ext = bus.dm_rd;
        endcase
    end

    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_we_d     = wb_we_q;
        wb_dst_d    = wb_dst_q;
        wb_data_d   = wb_data_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_store_d = err_store_q;
        if (!bus.stall) begin
            wb_valid_d = w_go;
            wb_we_d    = w_ld;
            if (w_ld) begin
                wb_dst_d  = bus.req_dst;
                wb_data_d = w_ext;
            end else if (w_st) begin
                wb_dst_d  = 5'd0;
                wb_data_d = 32'd0;
            end
            // A fresh capture takes priority over a simultaneous clear.
            if (w_active && w_misal && (!err_valid_q || bus.err_clr)) begin
                err_valid_d = 1'b1;
                err_addr_d  = bus.req_addr;
                err_store_d = bus.req_wr;
            end else if (bus.err_clr) begin
                err_valid_d = 1'b0;
                err_addr_d  = 32'd0;
                err_store_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_dst_q    <= 5'd0;
            wb_data_q   <= 32'd0;
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'd0;
            err_store_q <= 1'b0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_dst_q    <= wb_dst_d;
            wb_data_q   <= wb_data_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_store_q <= err_store_d;
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_we     = wb_we_q;
    assign bus.wb_dst    = wb_dst_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_store = err_store_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_unit.sv
//------------------------------------------------------------------------------
// tb_dm_access_unit : directed vector bench with a 2K-word memory model
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_access_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   wcnt   = 0;

    always #5 clk = ~clk;

    dm_access_if bus ();

    dm_access_unit #(.ADDR_LSB(2), .ADDR_MSB(12)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:2047];
    assign bus.dm_rd = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (bus.dm_be != 4'b0000) begin
            wcnt <= wcnt + 1;
            for (int b = 0; b < 4; b++)
                if (bus.dm_be[b]) mem[bus.dm_addr][8*b +: 8] <= bus.dm_wd[8*b +: 8];
        end
    end

    typedef struct {
        logic        val, rd, wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata;
        logic [4:0]  dst;
        logic        stall, flush, clr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_wd;
        logic        wbv, wbwe;
        logic [31:0] wbd;
        logic [4:0]  wbdst;
        logic        chk_d;
        logic        ev;
        logic [31:0] ea;
        logic        es;
    } vec_t;

    function automatic vec_t mk(
        input logic val, input logic rd, input logic wr, input logic [1:0] size, input logic uns,
        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dst,
        input logic stall, input logic flush, input logic clr,
        input logic [3:0] be, input logic [31:0] wd, input logic chk_wd,
        input logic wbv, input logic wbwe, input logic [31:0] wbd, input logic [4:0] wbdst, input logic chk_d,
        input logic ev, input logic [31:0] ea, input logic es);
        vec_t v;
        v.val = val; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.dst = dst;
        v.stall = stall; v.flush = flush; v.clr = clr;
        v.be = be; v.wd = wd; v.chk_wd = chk_wd;
        v.wbv = wbv; v.wbwe = wbwe; v.wbd = wbd; v.wbdst = wbdst; v.chk_d = chk_d;
        v.ev = ev; v.ea = ea; v.es = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req_valid = v.val;  bus.req_rd = v.rd;     bus.req_wr = v.wr;
        bus.req_size  = v.size; bus.req_uns = v.uns;   bus.req_addr = v.addr;
        bus.req_wdata = v.wdata; bus.req_dst = v.dst;
        bus.stall = v.stall;    bus.flush = v.flush;   bus.err_clr = v.clr;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] exp_addr;
        @(negedge clk);
        drive(v);
        #1;
        exp_addr = {21'd0, v.addr[12:2]};
        chk($sformatf("dm_addr[%0d]", idx), {21'd0, bus.dm_addr}, exp_addr);
        chk($sformatf("dm_be[%0d]", idx), {28'd0, bus.dm_be}, {28'd0, v.be});
        if (v.chk_wd) chk($sformatf("dm_wd[%0d]", idx), bus.dm_wd, v.wd);
        @(posedge clk);
        #1;
        chk($sformatf("wb_valid[%0d]", idx), {31'd0, bus.wb_valid}, {31'd0, v.wbv});
        chk($sformatf("wb_we[%0d]", idx), {31'd0, bus.wb_we}, {31'd0, v.wbwe});
        if (v.chk_d) begin
            chk($sformatf("wb_data[%0d]", idx), bus.wb_data, v.wbd);
            chk($sformatf("wb_dst[%0d]", idx), {27'd0, bus.wb_dst}, {27'd0, v.wbdst});
        end
        chk($sformatf("err_valid[%0d]", idx), {31'd0, bus.err_valid}, {31'd0, v.ev});
        chk($sformatf("err_addr[%0d]", idx), bus.err_addr, v.ea);
        chk($sformatf("err_store[%0d]", idx), {31'd0, bus.err_store}, {31'd0, v.es});
    endtask

    vec_t tbl[$];
    int   wbase;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        // args: val rd wr size uns addr wdata dst | stall flush clr | be wd chk_wd | wbv wbwe wbd wbdst chk_d | ev ea es
        tbl.push_back(mk(1,0,1,2'd0,0,32'h6,32'h000000A5,0, 0,0,0, 4'b0100,32'hA5A5A5A5,1, 1,0,32'h0,0,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd0,0,32'h6,32'h0,5, 0,0,0, 4'b0000,32'h0,0, 1,1,32'hFFFFFFA5,5,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd0,1,32'h6,32'h0,6, 0,0,0, 4'b0000,32'h0,0, 1,1,32'h000000A5,6,1, 0,32'h0,0));
        tbl.push_back(mk(1,0,1,2'd1,0,32'hA,32'h12348001,0, 0,0,0, 4'b1100,32'h80018001,1, 1,0,32'h0,0,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd1,0,32'hA,32'h0,7, 0,0,0, 4'b0000,32'h0,0, 1,1,32'hFFFF8001,7,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd1,1,32'hA,32'h0,8, 0,0,0, 4'b0000,32'h0,0, 1,1,32'h00008001,8,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd2,0,32'h8,32'h0,9, 0,0,0, 4'b0000,32'h0,0, 1,1,32'h80010000,9,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd2,0,32'h102,32'h0,10, 0,0,0, 4'b0000,32'h0,0, 0,0,32'h0,0,0, 1,32'h102,0));
        tbl.push_back(mk(1,0,1,2'd1,0,32'h3,32'h1111,0, 0,0,0, 4'b0000,32'h0,0, 0,0,32'h0,0,0, 1,32'h102,0));
        tbl.push_back(mk(1,0,1,2'd1,0,32'h3,32'h1111,0, 0,0,1, 4'b0000,32'h0,0, 0,0,32'h0,0,0, 1,32'h3,1));
        tbl.push_back(mk(0,0,0,2'd0,0,32'h0,32'h0,0, 0,0,1, 4'b0000,32'h0,0, 0,0,32'h0,0,0, 0,32'h0,0));
        tbl.push_back(mk(1,1,1,2'd2,0,32'h41,32'h0,3, 0,0,0, 4'b0000,32'h0,0, 0,0,32'h0,0,0, 0,32'h0,0));
        tbl.push_back(mk(1,0,1,2'd3,0,32'h44,32'hFFFFFFFF,0, 0,0,0, 4'b0000,32'h0,0, 0,0,32'h0,0,0, 0,32'h0,0));
        tbl.push_back(mk(1,0,1,2'd0,0,32'h2003,32'h0000005A,0, 0,0,0, 4'b1000,32'h5A5A5A5A,1, 1,0,32'h0,0,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd2,0,32'h0,32'h0,11, 0,0,0, 4'b0000,32'h0,0, 1,1,32'h5A000000,11,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd0,0,32'h3,32'h0,12, 0,0,0, 4'b0000,32'h0,0, 1,1,32'h0000005A,12,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd1,0,32'h2,32'h0,13, 0,0,0, 4'b0000,32'h0,0, 1,1,32'h00005A00,13,1, 0,32'h0,0));
        tbl.push_back(mk(1,0,1,2'd2,0,32'h20,32'hCAFEF00D,0, 0,0,0, 4'b1111,32'hCAFEF00D,1, 1,0,32'h0,0,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd2,0,32'h20,32'h0,14, 0,0,0, 4'b0000,32'h0,0, 1,1,32'hCAFEF00D,14,1, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,2'd2,0,32'h10,32'h0,15, 0,0,0, 4'b0000,32'h0,0, 1,1,32'hDEADBEEF,15,1, 0,32'h0,0));

        // Reset held with an active word store pending
        rst_n = 1'b0;
        drive(mk(1,0,1,2'd2,0,32'h10,32'hDEADBEEF,0, 0,0,0, 4'b1111,32'hDEADBEEF,1, 1,0,32'h0,0,1, 0,32'h0,0));
        repeat (3) @(negedge clk);
        chk("rst_dm_be", {28'd0, bus.dm_be}, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("rst_wb_dst", {27'd0, bus.wb_dst}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_err_valid", {31'd0, bus.err_valid}, 32'd0);
        chk("rst_err_addr", bus.err_addr, 32'd0);
        chk("rst_err_store", {31'd0, bus.err_store}, 32'd0);
        chk("rst_no_write", mem[4], 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_dm_be", {28'd0, bus.dm_be}, 32'h0000000F);
        chk("rel_dm_wd", bus.dm_wd, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        chk("rel_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("rel_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("rel_mem", mem[4], 32'hDEADBEEF);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Store held by stall (third cycle also flushed): hold outputs, then one write
        wbase = wcnt;
        for (int s = 0; s < 3; s++)
            apply(mk(1,0,1,2'd2,0,32'h30,32'h11223344,0, 1,(s==2),0, 4'b0000,32'h0,0, 1,1,32'hDEADBEEF,15,1, 0,32'h0,0), 100+s);
        chk("stall_no_write", wcnt, wbase);
        apply(mk(1,0,1,2'd2,0,32'h30,32'h11223344,0, 0,0,0, 4'b1111,32'h11223344,1, 1,0,32'h0,0,1, 0,32'h0,0), 103);
        chk("stall_one_write", wcnt, wbase + 1);
        apply(mk(1,1,0,2'd2,0,32'h30,32'h0,1, 0,0,0, 4'b0000,32'h0,0, 1,1,32'h11223344,1,1, 0,32'h0,0), 104);

        // Flushed store must not modify memory
        wbase = wcnt;
        apply(mk(1,0,1,2'd2,0,32'h30,32'h99999999,0, 0,1,0, 4'b0000,32'h0,0, 0,0,32'h0,0,0, 0,32'h0,0), 105);
        chk("flush_no_write", wcnt, wbase);
        apply(mk(1,1,0,2'd2,0,32'h30,32'h0,2, 0,0,0, 4'b0000,32'h0,0, 1,1,32'h11223344,2,1, 0,32'h0,0), 106);

        @(negedge clk);
        drive(mk(0,0,0,2'd0,0,32'h0,32'h0,0, 0,0,0, 4'b0000,32'h0,0, 0,0,32'h0,0,0, 0,32'h0,0));
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
MEM-stage load/store unit that sits directly upstream of the 2K-word data memory. It takes the registered EX/MEM access request and drives the memory's word address, byte enables and lane-aligned write data. It extracts and sign/zero-extends the memory's combinational read word for loads. Results are registered into the MEM/WB boundary, and misaligned accesses are trapped with a sticky error record.

Parameters:
ADDR_LSB, 2, lowest byte-address bit used for the word index
ADDR_MSB, 12, highest byte-address bit used for the word index (2048 words)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  EX/MEM request valid this cycle
req_rd  in  1  load request
req_wr  in  1  store request (req_rd and req_wr both high is illegal, treated as no-op)
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal (no-op)
req_uns  in  1  load zero-extend when 1, sign-extend when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_dst  in  5  load destination register
stall  in  1  hold MEM/WB outputs, suppress memory write
flush  in  1  kill the current request
err_clr  in  1  clear sticky error record
dm_addr  out  11  word address to data memory = req_addr[12:2]
dm_wd  out  32  lane-replicated write data
dm_be  out  4  byte enables to data memory
dm_rd  in  32  combinational read word from data memory
wb_valid  out  1  MEM/WB entry valid
wb_we  out  1  register-file write for a completed load
wb_dst  out  5  destination register
wb_data  out  32  extended load data
err_valid  out  1  sticky misalignment flag
err_addr  out  32  first offending byte address
err_store  out  1  offending access was a store

Behaviour:
- Reset (rst_n low, asynchronous): wb_valid=0, wb_we=0, wb_dst=0, wb_data=0, err_valid=0, err_addr=0, err_store=0. dm_be is forced to 0 while in reset.
- A request is active when req_valid & ~flush & ~stall & legal. Legal means exactly one of req_rd or req_wr is set and req_size != 11.
- A request is misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0]!=0.
- dm_addr is combinational and always driven from req_addr[12:2]. Upper address bits are ignored, so addresses alias modulo 8 KB.
- Store, combinational in the access cycle: dm_be is non-zero only for an active, aligned store.
  - Byte: be = 0001 shifted left by addr[1:0]; dm_wd = {4{wdata[7:0]}}.
  - Half: be = 0011 when addr[1]=0, 1100 when addr[1]=1; dm_wd = {2{wdata[15:0]}}.
  - Word: be = 1111; dm_wd = wdata.
  - The memory commits the store at the same rising edge. Store latency is 0 cycles beyond the access cycle.
  - All other cases: dm_be = 0000, dm_wd = wdata (don't-care).
- Load: dm_rd is read combinationally in the access cycle.
  - Select byte dm_rd[8*addr[1:0]+:8], halfword dm_rd[16*addr[1]+:16], or the full word.
  - Extend per req_uns.
  - Register at the rising edge: wb_data = extended value, wb_dst = req_dst, wb_we = 1, wb_valid = 1. Load-to-WB latency is 1 cycle.
- Store completion: at the next edge wb_valid=1, wb_we=0, wb_data=0, wb_dst=0.
- Non-request cycle (req_valid=0, or illegal): wb_valid=0, wb_we=0 at the next edge.
- flush=1 (and stall=0): no memory write; next edge wb_valid=0, wb_we=0. flush wins over req_valid.
- stall=1: no memory write, all wb_* hold, error record unchanged. stall wins over flush. Upstream holds the request; it executes exactly once, on the first cycle stall=0.
- Misaligned active request:
  - No write; next edge wb_valid=0, wb_we=0.
  - If err_valid=0: err_valid<=1, err_addr<=req_addr, err_store<=req_wr.
  - If err_valid=1, the first error is kept (later misalignments are ignored).
- err_clr=1: err_valid, err_addr and err_store are cleared at the next edge. When err_clr coincides with a new misalignment, the new capture wins (err_valid=1 with the new address).
- Back-to-back accesses need no bubble. A load to a word stored in the prior cycle returns the new data, because the memory write has committed.
- Reset mid-stall or mid-flush: everything clears immediately. No write occurs while rst_n=0.

Test Plan:
- Reset: hold rst_n=0 with an active SW request -> dm_be=0000, all wb_*/err_* are 0; release -> the SW proceeds normally.
- SB wdata=0x000000A5 at addr 0x0000_0006 -> dm_addr=1, dm_be=0100, dm_wd=0xA5A5A5A5. Then LB at the same addr -> wb_data=0xFFFFFFA5, wb_we=1. Then LBU -> 0x000000A5.
- SH 0x1234_8001 at addr 0x0A -> dm_be=1100. Then LH at addr 0x0A -> wb_data=0xFFFF8001. LHU -> 0x00008001. LW at 0x08 -> upper half 0x8001, lower half unchanged.
- LW at addr 0x0000_0102 -> no write, wb_valid=0 next cycle, err_valid=1, err_addr=0x102, err_store=0. A following SH at 0x3 -> err_addr stays 0x102. Assert err_clr together with SH at 0x3 -> err_addr=0x3, err_store=1.
- SW with stall=1 for 3 cycles, then stall=0 -> dm_be=0000 during the stall, wb_* held at previous values; exactly one write of 1111 on release, wb_valid=1 next edge.
- SW with flush=1 -> dm_be=0000, wb_valid=0 next edge. A subsequent LW to the same word returns the old contents.
